// File: rtl/idma_mp_dist_ooo_midend.sv
// rtl/idma_mp_dist_ooo_midend.sv - multi-port distribution midend with in-order tracking of outstanding requests
//
// Splits each 1D request across NumBEs back-ends by address region and keeps up to
// NumOutstanding requests in flight. Responses return to the manager in request order.
// Optional feature macro: IDMA_MP_DIST_RSP_MERGE_EN (per-BE response FIFOs, OR-merged response).
//
// Ports:
//   clk_i, rst_ni                          clock, asynchronous active-low reset
//   idma_req_i {src, dst, length}          incoming request, valid/ready handshake
//   idma_rsp_o                             merged response, valid/ready handshake
//   idma_busy_o {tracker_busy, be_busy}    registered OR of back-end busy plus tracker non-empty (MSB)
//   idma_req_o [NumBEs]                    sliced requests, per-BE valid/ready
//   idma_rsp_i [NumBEs]                    back-end responses, per-BE valid/ready
//   idma_busy_i [NumBEs]                   back-end busy vectors
module idma_mp_dist_ooo_midend #(
   parameter int unsigned          NumBEs         = 4,
   parameter int unsigned          RegionWidth    = 32'h100,
   parameter int unsigned          AddrWidth      = 32,
   parameter logic [AddrWidth-1:0] RegionStart    = 32'h0000_0000,
   parameter logic [AddrWidth-1:0] RegionEnd      = 32'h1000_0000,
   parameter int unsigned          NumOutstanding = 4,
   parameter int unsigned          RspWidth       = 8,
   parameter int unsigned          BusyWidth      = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [3*AddrWidth-1:0]          idma_req_i,
   input  logic                            idma_req_valid_i,
   output logic                            idma_req_ready_o,
   output logic [RspWidth-1:0]             idma_rsp_o,
   output logic                            idma_rsp_valid_o,
   input  logic                            idma_rsp_ready_i,
   output logic [BusyWidth:0]              idma_busy_o,
   output logic [NumBEs*3*AddrWidth-1:0]   idma_req_o,
   output logic [NumBEs-1:0]               idma_req_valid_o,
   input  logic [NumBEs-1:0]               idma_req_ready_i,
   input  logic [NumBEs*RspWidth-1:0]      idma_rsp_i,
   input  logic [NumBEs-1:0]               idma_rsp_valid_i,
   output logic [NumBEs-1:0]               idma_rsp_ready_o,
   input  logic [NumBEs*BusyWidth-1:0]     idma_busy_i
);

   localparam int unsigned ReqWidth = 3 * AddrWidth;
   localparam int unsigned OffWidth = AddrWidth + 1;
   localparam int unsigned DmaBits  = $clog2(RegionWidth);
   localparam int unsigned PtrWidth = $clog2(NumOutstanding);
   localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);
   localparam logic [AddrWidth-1:0] FullMask = AddrWidth'(NumBEs * RegionWidth - 1);

   logic [AddrWidth-1:0] src_addr, dst_addr, length, side_addr, other_addr;
   logic                 src_side;
   logic [OffWidth-1:0]  s_off, e_off;
   logic [NumBEs-1:0]    involved, sent_q, be_hs, rsp_inc, pc_nz, head_mask;
   logic                 tracker_full, req_accept, head_done, rsp_pop;
   logic [NumBEs-1:0]    trk_mask_q [NumOutstanding];
   logic [PtrWidth-1:0]  trk_wr_q, trk_rd_q;
   logic [CntWidth-1:0]  trk_cnt_q;
   logic [CntWidth-1:0]  pc_q [NumBEs];
   logic [BusyWidth-1:0] busy_or, busy_q;

   assign {src_addr, dst_addr, length} = idma_req_i;
   assign src_side   = (src_addr >= RegionStart) && (src_addr < RegionEnd);
   assign side_addr  = src_side ? src_addr : dst_addr;
   assign other_addr = src_side ? dst_addr : src_addr;
   // Offset inside the striped window; the end offset carries one extra bit so a
   // request reaching the very top of the window is still representable.
   assign s_off = OffWidth'(side_addr & FullMask);
   assign e_off = s_off + OffWidth'(length);

   always_comb begin
      logic [OffWidth-1:0]  lo, hi, cut;
      logic [AddrWidth-1:0] s_src, s_dst, s_len, reg_a, oth_a;
      involved   = '0;
      idma_req_o = '0;
      for (int i = 0; i < NumBEs; i++) begin
         lo    = OffWidth'(i * RegionWidth);
         hi    = OffWidth'((i + 1) * RegionWidth);
         cut   = (e_off < hi) ? e_off : hi;
         s_src = '0;
         s_dst = '0;
         s_len = AddrWidth'(1);
         reg_a = (side_addr & ~FullMask) | AddrWidth'(i * RegionWidth);
         oth_a = other_addr + AddrWidth'(i * RegionWidth) - AddrWidth'(s_off[DmaBits-1:0]);
         involved[i] = (length != '0) && (s_off < hi) && (e_off > lo);
         if (involved[i]) begin
            if (s_off >= lo) begin
               // first slice keeps the original addresses
               s_src = src_addr;
               s_dst = dst_addr;
               s_len = AddrWidth'(cut - s_off);
            end else begin
               s_src = src_side ? reg_a : oth_a;
               s_dst = src_side ? oth_a : reg_a;
               s_len = AddrWidth'(cut - lo);
            end
         end
         idma_req_o[i*ReqWidth +: ReqWidth] = {s_src, s_dst, s_len};
      end
   end

   // Fork: a BE that already took its slice is masked off until the whole request is accepted.
   assign tracker_full     = (trk_cnt_q == CntWidth'(NumOutstanding));
   assign idma_req_valid_o = {NumBEs{idma_req_valid_i & ~tracker_full & rst_ni}} & involved & ~sent_q;
   assign be_hs            = idma_req_valid_o & idma_req_ready_i;
   assign idma_req_ready_o = rst_ni & ~tracker_full & (&(~involved | sent_q | be_hs));
   assign req_accept       = idma_req_valid_i & idma_req_ready_o;

   always_comb begin
      busy_or = '0;
      for (int i = 0; i < NumBEs; i++) begin
         busy_or          = busy_or | idma_busy_i[i*BusyWidth +: BusyWidth];
         idma_rsp_ready_o[i] = pc_q[i] < CntWidth'(NumOutstanding);
         pc_nz[i]         = pc_q[i] != '0;
      end
   end

   assign rsp_inc          = idma_rsp_valid_i & idma_rsp_ready_o;
   assign head_mask        = trk_mask_q[trk_rd_q];
   assign head_done        = (trk_cnt_q != '0) && (&(~head_mask | pc_nz));
   assign idma_rsp_valid_o = head_done;
   assign rsp_pop          = head_done & idma_rsp_ready_i;
   assign idma_busy_o      = {trk_cnt_q != '0, busy_q};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sent_q    <= '0;
         trk_wr_q  <= '0;
         trk_rd_q  <= '0;
         trk_cnt_q <= '0;
         busy_q    <= '0;
         for (int i = 0; i < NumBEs; i++) pc_q[i] <= '0;
      end else begin
         sent_q <= req_accept ? '0 : (sent_q | be_hs);
         if (req_accept) trk_wr_q <= trk_wr_q + PtrWidth'(1);
         if (rsp_pop)    trk_rd_q <= trk_rd_q + PtrWidth'(1);
         trk_cnt_q <= trk_cnt_q + CntWidth'(req_accept) - CntWidth'(rsp_pop);
         busy_q    <= busy_or;
         for (int i = 0; i < NumBEs; i++)
            pc_q[i] <= pc_q[i] + CntWidth'(rsp_inc[i]) - CntWidth'(rsp_pop & head_mask[i]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (req_accept) trk_mask_q[trk_wr_q] <= involved;
   end

`ifdef IDMA_MP_DIST_RSP_MERGE_EN
   // Per-BE response FIFOs; their fill level tracks pc_q exactly.
   logic [RspWidth-1:0] rsp_mem [NumBEs][NumOutstanding];
   logic [PtrWidth-1:0] rsp_wr_q [NumBEs];
   logic [PtrWidth-1:0] rsp_rd_q [NumBEs];

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NumBEs; i++)
         if (rsp_inc[i]) rsp_mem[i][rsp_wr_q[i]] <= idma_rsp_i[i*RspWidth +: RspWidth];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NumBEs; i++) begin
            rsp_wr_q[i] <= '0;
            rsp_rd_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NumBEs; i++) begin
            if (rsp_inc[i])                 rsp_wr_q[i] <= rsp_wr_q[i] + PtrWidth'(1);
            if (rsp_pop && head_mask[i])    rsp_rd_q[i] <= rsp_rd_q[i] + PtrWidth'(1);
         end
      end
   end

   always_comb begin
      idma_rsp_o = '0;
      for (int i = 0; i < NumBEs; i++)
         if (head_mask[i]) idma_rsp_o = idma_rsp_o | rsp_mem[i][rsp_rd_q[i]];
   end
`else
   logic rsp_unused;
   assign rsp_unused = ^idma_rsp_i;
   assign idma_rsp_o = '0;
`endif

`ifndef SYNTHESIS
   // Requests must not run past the top of the striped window; there is no wrap.
   always @(posedge clk_i) begin
      if (rst_ni && idma_req_valid_i && (length != '0))
         assert (e_off <= OffWidth'(NumBEs * RegionWidth));
   end
`endif

endmodule

// File: tb/tb_idma_mp_dist_ooo_midend.sv
// tb/tb_idma_mp_dist_ooo_midend.sv - directed self-checking bench for idma_mp_dist_ooo_midend
module tb_idma_mp_dist_ooo_midend;
   localparam int NBE = 4;
   localparam int AW  = 32;
   localparam int RW  = 8;
   localparam int BW  = 4;
`ifdef IDMA_MP_DIST_RSP_MERGE_EN
   localparam bit Merge = 1'b1;
`else
   localparam bit Merge = 1'b0;
`endif

   logic                clk_i = 1'b0;
   logic                rst_ni;
   logic [3*AW-1:0]     req_i;
   logic                req_valid_i, req_ready_o;
   logic [RW-1:0]       rsp_o;
   logic                rsp_valid_o, rsp_ready_i;
   logic [BW:0]         busy_o;
   logic [NBE*3*AW-1:0] be_req;
   logic [NBE-1:0]      be_req_valid, be_req_ready;
   logic [NBE*RW-1:0]   be_rsp;
   logic [NBE-1:0]      be_rsp_valid, be_rsp_ready;
   logic [NBE*BW-1:0]   be_busy;

   int total = 0;
   int bad = 0;
   int acc_cnt = 0;
   int be0_hs = 0;
   int acc0, hs0;

   idma_mp_dist_ooo_midend dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .idma_req_i       (req_i),
      .idma_req_valid_i (req_valid_i),
      .idma_req_ready_o (req_ready_o),
      .idma_rsp_o       (rsp_o),
      .idma_rsp_valid_o (rsp_valid_o),
      .idma_rsp_ready_i (rsp_ready_i),
      .idma_busy_o      (busy_o),
      .idma_req_o       (be_req),
      .idma_req_valid_o (be_req_valid),
      .idma_req_ready_i (be_req_ready),
      .idma_rsp_i       (be_rsp),
      .idma_rsp_valid_i (be_rsp_valid),
      .idma_rsp_ready_o (be_rsp_ready),
      .idma_busy_i      (be_busy)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (req_valid_i && req_ready_o) acc_cnt <= acc_cnt + 1;
      if (be_req_valid[0] && be_req_ready[0]) be0_hs <= be0_hs + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3*AW-1:0] slice(input int i);
      return be_req[i*3*AW +: 3*AW];
   endfunction

   initial begin
      rst_ni = 1'b0; req_i = '0; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
      be_req_ready = '0; be_rsp = '0; be_rsp_valid = '0; be_busy = '0;
      repeat (2) @(negedge clk_i);
      chk("rst_be_valid", be_req_valid, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      rst_ni = 1'b1;

      // busy passthrough, registered one cycle
      @(negedge clk_i); be_busy = 16'h0400;
      @(negedge clk_i); chk("busy_or", busy_o, 5'h04); be_busy = '0;
      @(negedge clk_i); chk("busy_clr", busy_o, 5'h00);

      // three-BE split
      req_i = {32'h0000_0080, 32'h8000_0000, 32'h0000_0200}; req_valid_i = 1'b1; be_req_ready = '0;
      #1;
      chk("t1_valid", be_req_valid, 4'b0111);
      chk("t1_be0", slice(0), {32'h0000_0080, 32'h8000_0000, 32'h0000_0080});
      chk("t1_be1", slice(1), {32'h0000_0100, 32'h8000_0080, 32'h0000_0100});
      chk("t1_be2", slice(2), {32'h0000_0200, 32'h8000_0180, 32'h0000_0080});
      chk("t1_ready_lo", req_ready_o, 0);
      be_req_ready = 4'hF; #1;
      chk("t1_ready", req_ready_o, 1);
      @(negedge clk_i); req_valid_i = 1'b0;
      chk("t1_busy", busy_o, 5'h10);
      be_rsp = 32'h0000_0401; be_rsp_valid = 4'b0011;
      @(negedge clk_i); be_rsp_valid = '0;
      chk("t1_partial", rsp_valid_o, 0);
      be_rsp_valid = 4'b0100;
      @(negedge clk_i); be_rsp_valid = '0;
      chk("t1_done", rsp_valid_o, 1);
      chk("t1_rsp", rsp_o, Merge ? 8'h05 : 8'h00);
      @(negedge clk_i);
      chk("t1_popped", rsp_valid_o, 0);
      chk("t1_idle", busy_o, 0);

      // dst-side single BE
      req_i = {32'h9000_0000, 32'h0000_0310, 32'h0000_0040}; req_valid_i = 1'b1; #1;
      chk("t2_valid", be_req_valid, 4'b1000);
      chk("t2_be3", slice(3), {32'h9000_0000, 32'h0000_0310, 32'h0000_0040});
      chk("t2_ready", req_ready_o, 1);
      @(negedge clk_i); req_valid_i = 1'b0;
      be_rsp = 32'h0200_0000; be_rsp_valid = 4'b1000;
      @(negedge clk_i); be_rsp_valid = '0;
      chk("t2_done", rsp_valid_o, 1);
      chk("t2_rsp", rsp_o, Merge ? 8'h02 : 8'h00);
      @(negedge clk_i);
      chk("t2_popped", rsp_valid_o, 0);

      // fill the tracker, then release out of order
      be_rsp = 32'h8040_2010;
      for (int k = 0; k < 4; k++) begin
         req_i = {32'(k * 256), 32'h8000_0000, 32'h0000_0010}; req_valid_i = 1'b1; #1;
         chk("t3_accept", req_ready_o, 1);
         @(negedge clk_i);
      end
      req_i = {32'h0000_0000, 32'h8000_0000, 32'h0000_0010}; #1;
      chk("t3_full_ready", req_ready_o, 0);
      chk("t3_full_valid", be_req_valid, 0);
      @(negedge clk_i);
      chk("t3_stall", req_ready_o, 0);
      req_valid_i = 1'b0;
      be_rsp_valid = 4'b1010;
      @(negedge clk_i); be_rsp_valid = '0;
      chk("t3_head_wait", rsp_valid_o, 0);
      be_rsp_valid = 4'b0001;
      @(negedge clk_i); be_rsp_valid = '0;
      chk("t3_a_valid", rsp_valid_o, 1);
      chk("t3_a_rsp", rsp_o, Merge ? 8'h10 : 8'h00);
      @(negedge clk_i);
      chk("t3_b_valid", rsp_valid_o, 1);
      chk("t3_b_rsp", rsp_o, Merge ? 8'h20 : 8'h00);
      @(negedge clk_i);
      chk("t3_c_wait", rsp_valid_o, 0);
      be_rsp_valid = 4'b0100;
      @(negedge clk_i); be_rsp_valid = '0;
      chk("t3_c_valid", rsp_valid_o, 1);
      chk("t3_c_rsp", rsp_o, Merge ? 8'h40 : 8'h00);
      @(negedge clk_i);
      chk("t3_d_valid", rsp_valid_o, 1);
      chk("t3_d_rsp", rsp_o, Merge ? 8'h80 : 8'h00);
      @(negedge clk_i);
      chk("t3_empty", rsp_valid_o, 0);
      chk("t3_idle", busy_o, 0);

      // zero-length request between two normal ones
      req_i = {32'h0000_0000, 32'h8000_0000, 32'h0000_0010}; req_valid_i = 1'b1;
      @(negedge clk_i);
      req_i = {32'h0000_0040, 32'h8000_0000, 32'h0000_0000}; #1;
      chk("t4_zero_valid", be_req_valid, 0);
      chk("t4_zero_ready", req_ready_o, 1);
      @(negedge clk_i);
      req_i = {32'h0000_0100, 32'h8000_0000, 32'h0000_0010};
      @(negedge clk_i); req_valid_i = 1'b0;
      be_rsp_valid = 4'b0010;
      @(negedge clk_i); be_rsp_valid = '0;
      chk("t4_wait", rsp_valid_o, 0);
      be_rsp_valid = 4'b0001;
      @(negedge clk_i); be_rsp_valid = '0;
      chk("t4_x_valid", rsp_valid_o, 1);
      chk("t4_x_rsp", rsp_o, Merge ? 8'h10 : 8'h00);
      @(negedge clk_i);
      chk("t4_z_valid", rsp_valid_o, 1);
      chk("t4_z_rsp", rsp_o, 8'h00);
      @(negedge clk_i);
      chk("t4_y_valid", rsp_valid_o, 1);
      chk("t4_y_rsp", rsp_o, Merge ? 8'h20 : 8'h00);
      @(negedge clk_i);
      chk("t4_empty", rsp_valid_o, 0);

      // BE1 back-pressure, BE0 accepts immediately
      acc0 = acc_cnt; hs0 = be0_hs;
      req_i = {32'h0000_00C0, 32'h8000_1000, 32'h0000_0080}; req_valid_i = 1'b1; be_req_ready = 4'b0001; #1;
      chk("t5_valid", be_req_valid, 4'b0011);
      chk("t5_be0", slice(0), {32'h0000_00C0, 32'h8000_1000, 32'h0000_0040});
      chk("t5_be1", slice(1), {32'h0000_0100, 32'h8000_1040, 32'h0000_0040});
      chk("t5_ready_lo", req_ready_o, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         chk("t5_drop", be_req_valid, 4'b0010);
         chk("t5_hold", req_ready_o, 0);
      end
      be_req_ready = 4'hF; #1;
      chk("t5_ready", req_ready_o, 1);
      @(negedge clk_i); req_valid_i = 1'b0;
      chk("t5_accepts", acc_cnt - acc0, 1);
      chk("t5_be0_once", be0_hs - hs0, 1);
      be_rsp = 32'h0000_0401; be_rsp_valid = 4'b0011;
      @(negedge clk_i); be_rsp_valid = '0;
      chk("t5_done", rsp_valid_o, 1);
      chk("t5_merge", rsp_o, Merge ? 8'h05 : 8'h00);
      @(negedge clk_i);
      chk("t5_popped", rsp_valid_o, 0);

      // asynchronous reset mid-transfer
      req_i = {32'h0000_0000, 32'h8000_0000, 32'h0000_0010}; req_valid_i = 1'b1;
      @(negedge clk_i);
      req_i = {32'h0000_0100, 32'h8000_0000, 32'h0000_0010}; be_req_ready = '0; #1;
      chk("t6_pre_valid", be_req_valid, 4'b0010);
      chk("t6_pre_busy", busy_o, 5'h10);
      rst_ni = 1'b0; #1;
      chk("t6_rst_valid", be_req_valid, 0);
      chk("t6_rst_ready", req_ready_o, 0);
      chk("t6_rst_rsp", rsp_valid_o, 0);
      chk("t6_rst_busy", busy_o, 0);
      @(negedge clk_i);
      req_valid_i = 1'b0; rst_ni = 1'b1; be_req_ready = 4'hF;
      @(negedge clk_i);
      chk("t6_no_rsp", rsp_valid_o, 0);
      chk("t6_empty", busy_o, 0);
      req_i = {32'h0000_0300, 32'h8000_0000, 32'h0000_0010}; req_valid_i = 1'b1; #1;
      chk("t6_fresh_valid", be_req_valid, 4'b1000);
      @(negedge clk_i); req_valid_i = 1'b0;
      be_rsp_valid = 4'b1000;
      @(negedge clk_i); be_rsp_valid = '0;
      chk("t6_fresh_rsp", rsp_valid_o, 1);
      @(negedge clk_i);
      chk("t6_fresh_pop", rsp_valid_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
